instruction_fetch: RTL

Instruction fetch stage plus IF/ID pipeline register for the 5-stage ARM core. Owns the program counter and drives the address side of the combinational instruction memory. Captures the returned 32-bit word into the IF/ID register. Supports hazard freeze and branch redirect/flush from the EX stage.

---
 rtl/instruction_fetch_if.sv | 9 +
 rtl/instruction_fetch.sv | 64 ++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction-memory bus between the fetch stage and a combinational imem
//   imem_addr        : byte address of the word being fetched (driven by the fetch stage)
//   imem_instruction : 32-bit word at imem_addr, returned in the same cycle
interface instruction_fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instruction;
    modport master (output imem_addr, input imem_instruction);
    modport slave  (input imem_addr, output imem_instruction);
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, combinational imem fetch and IF/ID pipeline register
//   clk            : core clock, all state updates on the rising edge
//   rst_n          : asynchronous active-low reset
//   freeze         : hazard stall, holds PC and IF/ID
//   branch_taken   : EX branch resolved taken, redirects PC and flushes IF/ID
//   branch_addr    : absolute byte target of the taken branch
//   imem           : instruction memory bus (address out, same-cycle word in)
//   if_pc          : PC+PC_STEP of the captured instruction
//   if_instruction : captured instruction word (zero for a bubble)
//   if_valid       : 1 when if_instruction is a real fetched instruction
//   fetch_count    : number of instructions loaded into IF/ID, wraps at 2^32
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       freeze,
    input  logic                       branch_taken,
    input  logic [31:0]                branch_addr,
    instruction_fetch_if.master        imem,
    output logic [31:0]                if_pc,
    output logic [31:0]                if_instruction,
    output logic                       if_valid,
    output logic [31:0]                fetch_count
);

    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic [31:0] pc_next;
    logic        load;

    // A branch in EX always advances, so it overrides a freeze.
    always_comb begin
        pc_plus = pc + PC_STEP;
        load    = !branch_taken && !freeze;
        pc_next = branch_taken ? branch_addr : (freeze ? pc : pc_plus);
    end

    assign imem.imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            if_pc          <= '0;
            if_instruction <= '0;
            if_valid       <= 1'b0;
            fetch_count    <= '0;
        end else begin
            pc <= pc_next;
            if (branch_taken) begin
                if_pc          <= '0;
                if_instruction <= '0;
                if_valid       <= 1'b0;
            end else if (load) begin
                if_pc          <= pc_plus;
                if_instruction <= imem.imem_instruction;
                if_valid       <= 1'b1;
                fetch_count    <= fetch_count + 32'd1;
            end
        end
    end

endmodule
